// File: rtl/cmp_mon_pkg.sv
// Shared definitions for the comparator window monitor: relation codes and
// the reference unsigned compare used by the decoder.
package cmp_mon_pkg;

  localparam logic [1:0] REL_NONE = 2'b00;
  localparam logic [1:0] REL_GT   = 2'b01;
  localparam logic [1:0] REL_EQ   = 2'b10;
  localparam logic [1:0] REL_LT   = 2'b11;

  // Operands are zero-extended to this width before comparison
  localparam int unsigned REL_CMP_W = 32;

  function automatic logic [1:0] rel_of(input logic [REL_CMP_W-1:0] a,
                                        input logic [REL_CMP_W-1:0] b);
    if (a > b)       return REL_GT;
    else if (a == b) return REL_EQ;
    else             return REL_LT;
  endfunction

endpackage

// File: rtl/cmp_rel_decode.sv
// Combinational unsigned classifier: (a,b) -> GT/EQ/LT relation code.
// WIDTH up to cmp_mon_pkg::REL_CMP_W.
module cmp_rel_decode
  import cmp_mon_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [1:0]       rel
);

  logic [REL_CMP_W-1:0] a_ext;
  logic [REL_CMP_W-1:0] b_ext;

  // Zero-extend operands and classify with the shared compare function
  always_comb begin
    a_ext            = '0;
    b_ext            = '0;
    a_ext[WIDTH-1:0] = a;
    b_ext[WIDTH-1:0] = b;
    rel              = rel_of(a_ext, b_ext);
  end

endmodule

// File: rtl/cmp_window_monitor.sv
// Debounced relation monitor for the magnitude comparator stream.
// A new relation commits after HOLD consecutive identical samples and each
// committed change is reported as a valid/ready event.
// Optional feature: define CMP_MON_STATS_EN to build saturating per-relation
// sample counters; otherwise gt_cnt/eq_cnt/lt_cnt read as zero.
module cmp_window_monitor
  import cmp_mon_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int HOLD  = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [1:0]       rel,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [1:0]       ev_old,
  output logic [1:0]       ev_new,
  output logic [CNT_W-1:0] gt_cnt,
  output logic [CNT_W-1:0] eq_cnt,
  output logic [CNT_W-1:0] lt_cnt
);

  localparam logic [3:0] HOLD_RUN = 4'(HOLD);

  function automatic logic [3:0] sat_run(input logic [3:0] r);
    return (r >= HOLD_RUN) ? HOLD_RUN : r + 4'd1;
  endfunction

  function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  logic [1:0] samp_rel_p0;
  logic       vld_p0;
  logic [1:0] cand_p1;
  logic [3:0] run_p1;
  logic [3:0] run_nxt_p0;
  logic       commit_p0;

  cmp_rel_decode #(.WIDTH(WIDTH)) u_dec (
    .a   (a),
    .b   (b),
    .rel (samp_rel_p0)
  );

  // Stage 0: accept, classify and decide whether this sample commits
  assign in_ready   = ~ev_valid | ev_ready;
  assign vld_p0     = in_valid & in_ready;
  assign run_nxt_p0 = (samp_rel_p0 == cand_p1) ? sat_run(run_p1) : 4'd1;
  assign commit_p0  = vld_p0 && (run_nxt_p0 == HOLD_RUN) && (samp_rel_p0 != rel);

  // Stage 1: debounce run, committed relation and the pending change event
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_p1  <= REL_NONE;
      run_p1   <= 4'd0;
      rel      <= REL_NONE;
      ev_valid <= 1'b0;
      ev_old   <= REL_NONE;
      ev_new   <= REL_NONE;
    end else if (clr) begin
      cand_p1  <= REL_NONE;
      run_p1   <= 4'd0;
      rel      <= REL_NONE;
      ev_valid <= 1'b0;
      ev_old   <= REL_NONE;
      ev_new   <= REL_NONE;
    end else begin
      if (vld_p0) begin
        cand_p1 <= samp_rel_p0;
        run_p1  <= run_nxt_p0;
      end
      // A commit can only happen on an accepted sample, so it never
      // overwrites an event the consumer has not been offered the chance to take
      if (commit_p0) begin
        rel      <= samp_rel_p0;
        ev_valid <= 1'b1;
        ev_old   <= rel;
        ev_new   <= samp_rel_p0;
      end else if (ev_valid && ev_ready) begin
        ev_valid <= 1'b0;
      end
    end
  end

`ifdef CMP_MON_STATS_EN
  logic [CNT_W-1:0] gt_q;
  logic [CNT_W-1:0] eq_q;
  logic [CNT_W-1:0] lt_q;

  // Stage 1: saturating per-relation counts of accepted samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gt_q <= '0;
      eq_q <= '0;
      lt_q <= '0;
    end else if (clr) begin
      gt_q <= '0;
      eq_q <= '0;
      lt_q <= '0;
    end else if (vld_p0) begin
      case (samp_rel_p0)
        REL_GT:  gt_q <= sat_cnt(gt_q);
        REL_EQ:  eq_q <= sat_cnt(eq_q);
        REL_LT:  lt_q <= sat_cnt(lt_q);
        default: ;
      endcase
    end
  end

  assign gt_cnt = gt_q;
  assign eq_cnt = eq_q;
  assign lt_cnt = lt_q;
`else
  assign gt_cnt = '0;
  assign eq_cnt = '0;
  assign lt_cnt = '0;
`endif

endmodule
